imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Responder side of the core's instruction-fetch interface. The core drives pc_address; this block returns instr in the same cycle.
- Before the core runs, the block receives a program over a byte stream and writes it into an internal word memory. It holds the core in reset throughout loading.
- After loading completes, it serves fetches from that memory and releases the core.
- Sits between the board-level byte source (UART/debug bridge) and the SingleCycle core's instr/pc_address/rst pins.

Parameters:
- ADDR_W, 8, word-address width of the program memory.
- DEPTH, 256, number of 32-bit words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; starts (or restarts) a program load.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- pc_address  in  32  core fetch byte address.
- instr  out  32  instruction returned to the core (combinational from pc_address and state).
- core_rst_n  out  1  active-low reset to the core; high only in RUN.
- busy  out  1  high in HDR0, HDR1, LOAD.
- loaded_words  out  ADDR_W+1  number of words in the current program.
- load_err  out  1  sticky; the header length exceeded DEPTH.
- fetch_fault  out  1  sticky; a misaligned or out-of-range fetch occurred in RUN.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, in_ready=0, core_rst_n=0, busy=0.
  - loaded_words=0, load_err=0, fetch_fault=0.
  - byte/word counters=0, instr=NOP (32'h00000013).
  - Memory contents are not reset.
- States: IDLE, HDR0, HDR1, LOAD, RUN.
- load_start, from any state:
  - Next state HDR0.
  - Clear counters, load_err and fetch_fault.
  - core_rst_n goes low on the next edge.
  - Any partial word is discarded.
  - load_start has priority over every other event.
- in_ready = (state in HDR0/HDR1/LOAD) && !load_start, so no byte is accepted in a load_start cycle.
- HDR0: on a transfer, latch the length low byte and go to HDR1.
- HDR1: on a transfer, latch the high byte, forming N (16-bit, little-endian).
  - N > DEPTH: set load_err and go to IDLE.
  - N == 0: loaded_words=0 and go to RUN.
  - Otherwise go to LOAD.
- LOAD:
  - Byte k (0..3) of each word fills bits [8k+7:8k] (little-endian).
  - On the 4th byte, write the assembled word to mem[word_cnt] and increment word_cnt.
  - When word_cnt reaches N: loaded_words=N and go to RUN on the same edge.
  - Bytes that arrive while in_ready=0 are not consumed; the source holds them.
- RUN:
  - core_rst_n=1, registered, so the core leaves reset on the cycle after entry.
  - No in_ready.
- Fetch in RUN (combinational, zero latency):
  - pc_address[1:0]==0 and pc_address[31:2] < loaded_words: instr = mem[pc_address[ADDR_W+1:2]].
  - Otherwise: instr=NOP, and fetch_fault is set at the next edge.
  - Upper pc bits beyond the range are compared, not truncated.
- Outside RUN: instr=NOP, and fetch_fault is not updated.
- Memory is one write port (clocked) and one asynchronous read port, with no read-during-write hazard: writes occur only outside RUN and reads matter only in RUN.
- Reset asserted mid-load: everything returns to reset values and the partial program is invalid (loaded_words=0).
- A word counter at DEPTH cannot overflow because N ≤ DEPTH is enforced.

Decomposition:
- Shared package imem_pkg holds:
  - state enum (IDLE, HDR0, HDR1, LOAD, RUN).
  - NOP_INSTR = 32'h00000013.
  - HDR_BYTES = 2.
- One sub-module: imem_ram (DEPTH x 32, synchronous write, asynchronous read), so a vendor RAM can be substituted.
- The FSM, byte assembler and fetch checker stay in imem_loader.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 mid-stream, then release.
  - Required: in_ready=0, core_rst_n=0, instr=32'h00000013, loaded_words=0, all flags 0.
- Nominal load:
  - Stimulus: load_start, then bytes 02 00 | 93 00 10 00 | 13 01 20 00.
  - Required: RUN entered on the edge of the 10th byte. core_rst_n=1 one cycle later. pc=0 gives instr=32'h00100093; pc=4 gives 32'h00200113.
- Out-of-range and misaligned fetch:
  - Stimulus: after the nominal load, pc=8, then pc=2.
  - Required: instr=NOP in both cases. fetch_fault=1 after the first edge and stays 1.
- Oversize header:
  - Stimulus: bytes 01 01 (N=257) with DEPTH=256.
  - Required: load_err=1, state IDLE, core_rst_n=0. A following load_start clears load_err.
- Restart mid-load with backpressure:
  - Stimulus: load_start during LOAD after 2 payload bytes, with in_valid held high on the same cycle.
  - Required: in_ready=0 that cycle and the byte is not consumed. The next accepted byte is treated as header byte 0.
- Zero-length load:
  - Stimulus: bytes 00 00.
  - Required: RUN after the 2nd byte with loaded_words=0. Any fetch returns NOP and sets fetch_fault.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Pure declarations: no latency, no flow control.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    LOAD,
    RUN
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          HDR_BYTES = 2;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 program store: clocked write port, asynchronous read port.
// Zero-latency read, one write per cycle, no backpressure.
module imem_ram
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program from a byte stream, then serves core fetches.
// Fetch is combinational; in_ready is high only while loading and never in a load_start cycle.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc_address,
  output logic [31:0]       instr,
  output logic              core_rst_n,
  output logic              busy,
  output logic [ADDR_W:0]   loaded_words,
  output logic              load_err,
  output logic              fetch_fault
);

  localparam logic [15:0]   DEPTH_LEN = 16'(DEPTH);
  localparam logic [ADDR_W:0] WORD_ONE = (ADDR_W+1)'(1);

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_len;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_word_cnt;
  logic [23:0]       r_word;
  logic [ADDR_W:0]   r_loaded_words;
  logic              r_load_err;
  logic              r_fetch_fault;
  logic              r_core_rst_n;

  logic              w_xfer;
  logic              w_we;
  logic              w_last_word;
  logic              w_fetch_ok;
  logic [15:0]       w_hdr_len;
  logic [ADDR_W:0]   w_word_inc;
  logic [31:0]       w_rdata;

  assign busy        = (r_state == HDR0) || (r_state == HDR1) || (r_state == LOAD);
  assign in_ready    = busy && !load_start;
  assign w_xfer      = in_valid && in_ready;
  assign w_hdr_len   = {in_data, r_len[7:0]};
  assign w_word_inc  = r_word_cnt + WORD_ONE;
  assign w_last_word = (16'(w_word_inc) == r_len);
  assign w_we        = w_xfer && (r_state == LOAD) && (r_byte_cnt == 2'd3);

  // Full-width compare so high pc bits cannot alias into the table.
  assign w_fetch_ok  = (pc_address[1:0] == 2'b00) &&
                       (pc_address[31:2] < 30'(r_loaded_words));
  assign instr       = ((r_state == RUN) && w_fetch_ok) ? w_rdata : NOP_INSTR;

  assign core_rst_n   = r_core_rst_n;
  assign loaded_words = r_loaded_words;
  assign load_err     = r_load_err;
  assign fetch_fault  = r_fetch_fault;

  always_comb begin
    w_state_nxt = r_state;
    if (load_start) begin
      w_state_nxt = HDR0;
    end else begin
      case (r_state)
        HDR0: if (w_xfer) w_state_nxt = HDR1;
        HDR1: begin
          if (w_xfer) begin
            if (w_hdr_len > DEPTH_LEN)   w_state_nxt = IDLE;
            else if (w_hdr_len == 16'd0) w_state_nxt = RUN;
            else                         w_state_nxt = LOAD;
          end
        end
        LOAD: if (w_we && w_last_word) w_state_nxt = RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len          <= '0;
      r_byte_cnt     <= '0;
      r_word_cnt     <= '0;
      r_word         <= '0;
      r_loaded_words <= '0;
      r_load_err     <= 1'b0;
      r_fetch_fault  <= 1'b0;
      r_core_rst_n   <= 1'b0;
    end else begin
      r_core_rst_n <= (r_state == RUN) && !load_start;
      if (load_start) begin
        r_len          <= '0;
        r_byte_cnt     <= '0;
        r_word_cnt     <= '0;
        r_word         <= '0;
        r_loaded_words <= '0;
        r_load_err     <= 1'b0;
        r_fetch_fault  <= 1'b0;
      end else begin
        if ((r_state == RUN) && !w_fetch_ok) r_fetch_fault <= 1'b1;
        if (w_xfer) begin
          case (r_state)
            HDR0: r_len[7:0] <= in_data;
            HDR1: begin
              r_len <= w_hdr_len;
              if (w_hdr_len > DEPTH_LEN) r_load_err <= 1'b1;
            end
            LOAD: begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              case (r_byte_cnt)
                2'd0: r_word[7:0]   <= in_data;
                2'd1: r_word[15:8]  <= in_data;
                2'd2: r_word[23:16] <= in_data;
                default: begin
                  r_word_cnt <= w_word_inc;
                  if (w_last_word) r_loaded_words <= w_word_inc;
                end
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_word_cnt[ADDR_W-1:0]),
    .i_wdata ({in_data, r_word}),
    .i_raddr (pc_address[ADDR_W+1:2]),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: per-cycle expectations from a byte/word-level model.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int AW  = 8;
  localparam int DEP = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   pc_address;
  logic [31:0]   instr;
  logic          core_rst_n;
  logic          busy;
  logic [AW:0]   loaded_words;
  logic          load_err;
  logic          fetch_fault;

  imem_loader #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc_address   (pc_address),
    .instr        (instr),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .loaded_words (loaded_words),
    .load_err     (load_err),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        core;
    logic        bsy;
    logic [AW:0] lw;
    logic        err;
    logic        fault;
    logic [31:0] ins;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: a mode, the header/payload byte queues and the program words.
  localparam int M_IDLE = 0, M_HDR = 1, M_LOAD = 2, M_RUN = 3;
  int          m_mode;
  logic [7:0]  m_hdr[$];
  logic [7:0]  m_pay[$];
  logic [31:0] m_prog[DEP];
  int          m_n;
  int          m_loaded;
  bit          m_err, m_fault, m_core;

  function automatic bit ref_hit(input logic [31:0] pc);
    return (m_mode == M_RUN) && (pc[1:0] == 2'b00) && ((pc >> 2) < 32'(m_loaded));
  endfunction

  function automatic exp_t make_exp(input bit ls, input logic [31:0] pc);
    exp_t e;
    e.bsy   = (m_mode == M_HDR) || (m_mode == M_LOAD);
    e.rdy   = e.bsy && !ls;
    e.core  = m_core;
    e.lw    = m_loaded[AW:0];
    e.err   = m_err;
    e.fault = m_fault;
    e.ins   = ref_hit(pc) ? m_prog[pc[AW+1:2]] : NOP_INSTR;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_hdr.delete();
    m_pay.delete();
    m_n = 0; m_loaded = 0;
    m_err = 1'b0; m_fault = 1'b0; m_core = 1'b0;
  endtask

  task automatic model_advance(input bit ls, input bit vld, input logic [7:0] d,
                               input logic [31:0] pc);
    bit nxt_core;
    bit xfer;
    int w;
    nxt_core = (m_mode == M_RUN) && !ls;
    xfer     = vld && !ls && ((m_mode == M_HDR) || (m_mode == M_LOAD));
    if (ls) begin
      m_mode = M_HDR;
      m_hdr.delete();
      m_pay.delete();
      m_loaded = 0; m_err = 1'b0; m_fault = 1'b0;
    end else begin
      if ((m_mode == M_RUN) && !ref_hit(pc)) m_fault = 1'b1;
      if (xfer && m_mode == M_HDR) begin
        m_hdr.push_back(d);
        if (m_hdr.size() == HDR_BYTES) begin
          m_n = int'(m_hdr[0]) + 256 * int'(m_hdr[1]);
          if (m_n > DEP)       begin m_err = 1'b1; m_mode = M_IDLE; end
          else if (m_n == 0)   m_mode = M_RUN;
          else                 m_mode = M_LOAD;
        end
      end else if (xfer && m_mode == M_LOAD) begin
        m_pay.push_back(d);
        if (m_pay.size() % 4 == 0) begin
          w = m_pay.size() / 4 - 1;
          m_prog[w[AW-1:0]] = {m_pay[4*w+3], m_pay[4*w+2], m_pay[4*w+1], m_pay[4*w]};
          if (w + 1 == m_n) begin m_loaded = m_n; m_mode = M_RUN; end
        end
      end
    end
    m_core = nxt_core;
  endtask

  // One clock cycle: drive, post the expectation, then let the model take the edge.
  task automatic step(input bit ls, input bit vld, input logic [7:0] d, input logic [31:0] pc);
    load_start = ls; in_valid = vld; in_data = d; pc_address = pc;
    sb_q.push_back(make_exp(ls, pc));
    @(posedge clk); #1;
    model_advance(ls, vld, d, pc);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b0; load_start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    model_reset();
    repeat (cyc) begin
      sb_q.push_back(make_exp(1'b0, pc_address));
      @(posedge clk); #1;
    end
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    case ($urandom_range(0, 3))
      0:       p = 32'(4 * $urandom_range(0, 9));
      1:       p = $urandom;
      2:       p = 32'(4 * $urandom_range(0, 9) + $urandom_range(1, 3));
      default: p = 32'h400 + 32'(4 * $urandom_range(0, 3));
    endcase
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 8'($urandom), rand_pc());
    step(1'b0, 1'b1, d, rand_pc());
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), pc);
  endtask

  task automatic load_prog(input int n, input int ab);
    step(1'b1, 1'b1, 8'($urandom), rand_pc());
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    if (n >= 1 && n <= DEP) begin
      for (int i = 0; i < 4 * n; i++) begin
        if (i == ab) break;
        send_byte(8'($urandom), 1'b1);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("in_ready",     32'(in_ready),     32'(e.rdy));
        chk("core_rst_n",   32'(core_rst_n),   32'(e.core));
        chk("busy",         32'(busy),         32'(e.bsy));
        chk("loaded_words", 32'(loaded_words), 32'(e.lw));
        chk("load_err",     32'(load_err),     32'(e.err));
        chk("fetch_fault",  32'(fetch_fault),  32'(e.fault));
        chk("instr",        instr,             e.ins);
      end
    end
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog expired");
  end

  logic [7:0] nom [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
  logic [7:0] rst_pre [6] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h01, 8'h00};
  logic [7:0] one_w [4] = '{8'h13, 8'h05, 8'h00, 8'h00};

  initial begin
    int n;
    int ab;
    rst = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00; pc_address = 32'h0;
    model_reset();
    @(posedge clk); #1;
    do_reset(3);

    // Nominal two-word program, then in-range, out-of-range, misaligned and aliasing fetches.
    step(1'b1, 1'b0, 8'h00, 32'h0);
    foreach (nom[i]) send_byte(nom[i], 1'b0);
    step(1'b0, 1'b0, 8'h00, 32'h0);
    step(1'b0, 1'b0, 8'h00, 32'h4);
    step(1'b0, 1'b0, 8'h00, 32'h0);
    step(1'b0, 1'b0, 8'h00, 32'h8);
    step(1'b0, 1'b1, 8'hAA, 32'h2);
    step(1'b0, 1'b0, 8'h00, 32'h4);
    step(1'b0, 1'b0, 8'h00, 32'h400);
    step(1'b0, 1'b0, 8'h00, 32'h8000_0000);

    // Oversize header, then a load_start clears the error.
    step(1'b1, 1'b0, 8'h00, 32'h0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h55, 32'h0);
    step(1'b0, 1'b1, 8'h55, 32'h0);
    step(1'b1, 1'b0, 8'h00, 32'h0);
    step(1'b0, 1'b0, 8'h00, 32'h0);

    // Restart during payload with in_valid high on the load_start cycle.
    step(1'b1, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 4; i++) send_byte(nom[i], 1'b0);
    step(1'b1, 1'b1, 8'h01, 32'h0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    foreach (one_w[i]) send_byte(one_w[i], 1'b0);
    step(1'b0, 1'b0, 8'h00, 32'h0);
    step(1'b0, 1'b0, 8'h00, 32'h0);
    step(1'b0, 1'b0, 8'h00, 32'h4);

    // Zero-length program.
    step(1'b1, 1'b0, 8'h00, 32'h0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 32'h0);
    step(1'b0, 1'b0, 8'h00, 32'h0);

    // Asynchronous reset in the middle of a payload.
    step(1'b1, 1'b0, 8'h00, 32'h0);
    foreach (rst_pre[i]) send_byte(rst_pre[i], 1'b0);
    do_reset(2);
    step(1'b0, 1'b1, 8'h11, 32'h0);
    step(1'b0, 1'b0, 8'h00, 32'h0);

    // Full-depth program and its last/past-last words.
    load_prog(DEP, -1);
    fetch(32'd1020);
    fetch(32'd1024);
    fetch(32'd0);
    fetch(32'd512);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = int'($urandom_range(257, 65535));
        default: n = int'($urandom_range(1, 12));
      endcase
      ab = -1;
      if (n >= 1 && n <= DEP && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, 4 * n - 1));
      load_prog(n, ab);
      if (ab >= 0 && $urandom_range(0, 1) == 1) do_reset(1);
      repeat (8) fetch(rand_pc());
    end

    repeat (3) step(1'b0, 1'b0, 8'h00, 32'h0);
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
